// File: rtl/rdcla_pkg.sv
// Shared definitions for the recursive-doubling carry-lookahead adder/subtractor family.
// Holds the k/p/g prefix encoding and the fixed datapath geometry.
package rdcla_pkg;

    localparam int WIDTH  = 32;
    localparam int LEVELS = 5;

    typedef logic [1:0] kpg_t;

    // Both 2'b01 and 2'b10 mean propagate; only kill and generate are named.
    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_GEN  = 2'b11;

endpackage

// File: rtl/rdcla_sub32_pipe_kpg_combine.sv
// Two-bit k/p/g prefix cell: a resolved (kill/generate) current bit wins,
// a propagating current bit passes the previous group's status through.
module kpg_combine
    import rdcla_pkg::*;
(
    input  kpg_t cur,
    input  kpg_t prev,
    output kpg_t comb
);

    assign comb = (cur[1] ^ cur[0]) ? prev : cur;

endmodule

// File: rtl/rdcla_sub32_pipe.sv
// Pipelined 32-bit recursive-doubling subtractor (diff = a + ~b + 1), one prefix level per stage,
// valid/ready handshake with bubble collapse. Optional zero/neg/ovf flags under RDSUB_FLAGS_EN.
module rdcla_sub32_pipe
    import rdcla_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef RDSUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    logic [2*WIDTH-1:0] kpg_in;
    logic [WIDTH-1:0]   xor_in;
    kpg_t               bit0_seeded;

    logic [2*WIDTH-1:0] lvl_out [1:LEVELS];
    logic [WIDTH-1:0]   xor_src [1:LEVELS];
    logic [LEVELS:1]    vld_src;

    logic [2*WIDTH-1:0] kpg_p [1:LEVELS];
    logic [WIDTH-1:0]   xor_p [1:LEVELS];
    logic [LEVELS:1]    vld_p;
    logic [LEVELS+1:1]  rdy;

`ifdef RDSUB_FLAGS_EN
    logic [LEVELS:1]    a_msb_src, b_msb_src;
    logic [LEVELS:1]    a_msb_p, b_msb_p;
`endif

    // Operand pair is (a[j], ~b[j]); bit 0 is pre-seeded with the +1 carry-in so
    // every bit resolves to kill or generate after the last level.
    kpg_combine u_seed (
        .cur  ({a[0], ~b[0]}),
        .prev (KPG_GEN),
        .comb (bit0_seeded)
    );

    always_comb begin
        kpg_in = '0;
        for (int j = 1; j < WIDTH; j++) begin
            kpg_in[2*j +: 2] = {a[j], ~b[j]};
        end
        kpg_in[1:0] = bit0_seeded;
    end

    assign xor_in  = a ^ ~b;
    assign vld_src = {vld_p[LEVELS-1:1], in_valid};

`ifdef RDSUB_FLAGS_EN
    assign a_msb_src = {a_msb_p[LEVELS-1:1], a[WIDTH-1]};
    assign b_msb_src = {b_msb_p[LEVELS-1:1], b[WIDTH-1]};
`endif

    // Ready chain runs tail to head so an empty stage always accepts.
    always_comb begin
        rdy = '0;
        rdy[LEVELS+1] = out_ready;
        for (int k = LEVELS; k >= 1; k--) begin
            rdy[k] = ~vld_p[k] | rdy[k+1];
        end
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_level
        localparam int DIST = 1 << (lv - 1);
        logic [2*WIDTH-1:0] cur_lvl;
        logic [2*WIDTH-1:0] nxt_lvl;

        if (lv == 1) begin : g_head
            assign cur_lvl     = kpg_in;
            assign xor_src[lv] = xor_in;
        end else begin : g_body
            assign cur_lvl     = kpg_p[lv-1];
            assign xor_src[lv] = xor_p[lv-1];
        end

        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            kpg_t prev_cell;
            if (j >= DIST) begin : g_span
                assign prev_cell = cur_lvl[2*(j-DIST) +: 2];
            end else begin : g_low
                assign prev_cell = KPG_GEN;
            end
            kpg_combine u_cell (
                .cur  (cur_lvl[2*j +: 2]),
                .prev (prev_cell),
                .comb (nxt_lvl[2*j +: 2])
            );
        end

        assign lvl_out[lv] = nxt_lvl;
    end

    // ---- stage registers p1..p5 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int k = 1; k <= LEVELS; k++) begin
                kpg_p[k] <= '0;
                xor_p[k] <= '0;
            end
`ifdef RDSUB_FLAGS_EN
            a_msb_p <= '0;
            b_msb_p <= '0;
`endif
        end else begin
            for (int k = 1; k <= LEVELS; k++) begin
                if (rdy[k]) begin
                    vld_p[k] <= vld_src[k];
                    kpg_p[k] <= lvl_out[k];
                    xor_p[k] <= xor_src[k];
`ifdef RDSUB_FLAGS_EN
                    a_msb_p[k] <= a_msb_src[k];
                    b_msb_p[k] <= b_msb_src[k];
`endif
                end
            end
        end
    end

    // ---- output: carries from the final prefix level ----
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_raw;

    always_comb begin
        carry = '0;
        for (int j = 0; j < WIDTH; j++) begin
            carry[j] = kpg_p[LEVELS][2*j+1];
        end
    end

    assign diff_raw  = xor_p[LEVELS] ^ {carry[WIDTH-2:0], 1'b1};
    assign out_valid = vld_p[LEVELS];
    assign in_ready  = rdy[1];
    assign diff      = vld_p[LEVELS] ? diff_raw : '0;
    assign borrow    = vld_p[LEVELS] & ~carry[WIDTH-1];

`ifdef RDSUB_FLAGS_EN
    assign zero = vld_p[LEVELS] & (diff_raw == '0);
    assign neg  = vld_p[LEVELS] & diff_raw[WIDTH-1];
    assign ovf  = vld_p[LEVELS] & (a_msb_p[LEVELS] ^ b_msb_p[LEVELS])
                                & (diff_raw[WIDTH-1] ^ a_msb_p[LEVELS]);
`endif

endmodule

// File: tb/tb_rdcla_sub32_pipe.sv
// Scoreboard bench for rdcla_sub32_pipe: directed vectors, stalled random burst,
// bubble collapse and mid-stream reset. Flag checks follow RDSUB_FLAGS_EN.
module tb_rdcla_sub32_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
`ifdef RDSUB_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    always #5 clk = ~clk;

    rdcla_sub32_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef RDSUB_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic        br;
        logic        z;
        logic        n;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    bit          check_lat = 1'b0;
    bit          held      = 1'b0;
    logic [32:0] hold_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor samples 2 time units after the falling edge; the driver changes inputs 1 unit after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    e.d   = a - b;
                    e.br  = (a < b);
                    e.z   = (e.d == 32'd0);
                    e.n   = e.d[31];
                    e.o   = (a[31] != b[31]) && (e.d[31] != a[31]);
                    e.cyc = cyc;
                    sb.push_back(e);
                    n_acc++;
                end
                if (out_valid) begin
                    if (!out_ready) begin
                        if (held) check("hold_out", {31'd0, borrow, diff}, {31'd0, hold_val});
                        held     = 1'b1;
                        hold_val = {borrow, diff};
                    end else begin
                        held = 1'b0;
                        if (sb.size() == 0) begin
                            check("unexpected_out", 64'd1, 64'd0);
                        end else begin
                            e = sb.pop_front();
                            check("diff", {32'd0, diff}, {32'd0, e.d});
                            check("borrow", {63'd0, borrow}, {63'd0, e.br});
`ifdef RDSUB_FLAGS_EN
                            check("flags", {61'd0, zero, neg, ovf}, {61'd0, e.z, e.n, e.o});
`endif
                            if (check_lat) check("latency", 64'(cyc - e.cyc), 64'd5);
                        end
                    end
                end else begin
                    held = 1'b0;
                    check("gated_idle", {31'd0, borrow, diff}, 64'd0);
                end
            end
        end
    end

    bit cap_watch = 1'b0;
    bit cap_seen  = 1'b0;
    int cap_base  = 0;

    task automatic drive_op(input logic [31:0] x, input logic [31:0] y);
        int waited;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        #2;
        waited = 0;
        while (!in_ready) begin
            if (cap_watch && !cap_seen) begin
                cap_seen = 1'b1;
                check("cap_full_at", 64'(n_acc - cap_base), 64'd5);
            end
            @(negedge clk);
            #3;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] dir_a [6] = '{32'd5, 32'd3, 32'h8000_0000, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] dir_b [6] = '{32'd3, 32'd5, 32'd1,         32'hDEAD_BEEF, 32'd1, 32'd0};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_diff", {31'd0, borrow, diff}, 64'd0);

        // Directed vectors, one at a time, unstalled: latency must be exactly 5.
        check_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_op(dir_a[i], dir_b[i]);
            idle();
            drain();
        end
        check_lat = 1'b0;

        // Eight back-to-back ops with the consumer stalled for cycles 3..9.
        cap_watch = 1'b1;
        cap_base  = n_acc;
        fork
            begin
                for (int i = 0; i < 8; i++) drive_op($urandom, $urandom);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                #1 out_ready = 1'b0;
                repeat (7) @(negedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        cap_watch = 1'b0;
        check("cap_seen", {63'd0, cap_seen}, 64'd1);

        // Bubble collapse: a lone transaction stalled at the tail must not block a new accept.
        @(negedge clk);
        #1 out_ready = 1'b0;
        drive_op(32'h1234_5678, 32'h0000_0678);
        idle();
        idle();
        @(negedge clk);
        #1;
        in_valid = 1'b1; a = 32'd100; b = 32'd200;
        #1;
        check("bubble_accept", {63'd0, in_ready}, 64'd1);
        idle();
        @(negedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset with three transactions in flight: all of them must vanish.
        @(negedge clk);
        #1 out_ready = 1'b0;
        drive_op(32'd10, 32'd1);
        drive_op(32'd20, 32'd2);
        drive_op(32'd30, 32'd3);
        @(negedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; a = 32'd77; b = 32'd7;
        sb.delete();
        @(negedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        #2;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        drive_op(32'h0000_0001, 32'h0000_0002);
        idle();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
